// File: rtl/entropy_encoder_pkg.sv
// ============================================================================
// Module : entropy_encoder_pkg
// Brief  : Shared widths and accumulator state encoding for the entropy encoder
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package entropy_encoder_pkg;

    localparam int c_range_width_default  = 16;
    localparam int c_symbol_width_default = 4;

    // Count of Boolean symbols currently held in the accumulator
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } bundle_state_e;

endpackage

`default_nettype wire

// File: rtl/bundle_timeout_counter.sv
// ============================================================================
// Module : bundle_timeout_counter
// Brief  : Saturating idle counter; o_expired once TIMEOUT_CYCLES idle cycles seen
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bundle_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_expired
);

    localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT_CYCLES);

    logic [c_cnt_w-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_count_en && (cnt_q != c_limit)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expired = (cnt_q == c_limit);

endmodule

`default_nettype wire

// File: rtl/symbol_bundler.sv
// ============================================================================
// Module : symbol_bundler
// Brief  : Packs 1-3 Boolean symbols or one CDF symbol per output bundle.
//          Optional idle flush of partial bundles under `BUNDLE_TIMEOUT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module symbol_bundler
    import entropy_encoder_pkg::*;
#(
    parameter int RANGE_WIDTH    = c_range_width_default,
    parameter int SYMBOL_WIDTH   = c_symbol_width_default,
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_bool,
    input  logic [SYMBOL_WIDTH-1:0] in_symbol,
    input  logic [RANGE_WIDTH-1:0]  in_fl,
    input  logic [RANGE_WIDTH-1:0]  in_fh,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_bool_flag_1,
    output logic                    out_bool_flag_2,
    output logic                    out_bool_flag_3,
    output logic [SYMBOL_WIDTH-1:0] out_symbol_1,
    output logic [SYMBOL_WIDTH-1:0] out_symbol_2,
    output logic [SYMBOL_WIDTH-1:0] out_symbol_3,
    output logic [RANGE_WIDTH-1:0]  out_fl,
    output logic [RANGE_WIDTH-1:0]  out_fh,
    output logic                    out_last
);

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    bundle_state_e           state_q, state_d;
    logic [SYMBOL_WIDTH-1:0] held1_q, held1_d, held2_q, held2_d;
    logic                    out_valid_q, out_valid_d;
    logic [2:0]              out_flags_q, out_flags_d;   // [2] = slot 1
    logic [SYMBOL_WIDTH-1:0] out_sym1_q, out_sym1_d, out_sym2_q, out_sym2_d;
    logic [SYMBOL_WIDTH-1:0] out_sym3_q, out_sym3_d;
    logic [RANGE_WIDTH-1:0]  out_fl_q, out_fl_d, out_fh_q, out_fh_d;
    logic                    out_last_q, out_last_d;

    logic slot_free, in_fire, flush_fire, timeout_hit;

    assign slot_free = !out_valid_q || out_ready;
    assign in_fire   = in_valid && in_ready;

    always_comb begin
        in_ready = 1'b1;
        if (in_bool) begin
            if ((state_q == TWO) || in_last) in_ready = slot_free;
        end else begin
            // A CDF symbol waits until any partial Boolean bundle has been flushed
            in_ready = (state_q == EMPTY) && slot_free;
        end
    end

    assign flush_fire = !in_fire && slot_free && (state_q != EMPTY) &&
                        ((in_valid && !in_bool) || timeout_hit);

`ifdef BUNDLE_TIMEOUT_EN
    bundle_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (in_fire || flush_fire || (state_q == EMPTY)),
        .i_count_en (state_q != EMPTY),
        .o_expired  (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        held1_d     = held1_q;
        held2_d     = held2_q;
        out_valid_d = out_valid_q && !out_ready;
        out_flags_d = out_flags_q;
        out_sym1_d  = out_sym1_q;
        out_sym2_d  = out_sym2_q;
        out_sym3_d  = out_sym3_q;
        out_fl_d    = out_fl_q;
        out_fh_d    = out_fh_q;
        out_last_d  = out_last_q;

        if (in_fire && in_bool && (state_q != TWO) && !in_last) begin
            if (state_q == EMPTY) begin
                held1_d = in_symbol;
                state_d = ONE;
            end else begin
                held2_d = in_symbol;
                state_d = TWO;
            end
        end else if (in_fire || flush_fire) begin
            out_valid_d = 1'b1;
            out_last_d  = in_fire && in_last;
            out_fl_d    = '0;
            out_fh_d    = '0;
            out_sym1_d  = '0;
            out_sym2_d  = '0;
            out_sym3_d  = '0;
            out_flags_d = 3'b000;
            state_d     = EMPTY;
            if (in_fire && !in_bool) begin
                out_sym1_d = in_symbol;
                out_fl_d   = in_fl;
                out_fh_d   = in_fh;
            end else begin
                // Held symbols fill the leading slots; an accepted Boolean follows them
                case (state_q)
                    ONE: begin
                        out_flags_d = 3'b100;
                        out_sym1_d  = held1_q;
                    end
                    TWO: begin
                        out_flags_d = 3'b110;
                        out_sym1_d  = held1_q;
                        out_sym2_d  = held2_q;
                    end
                    default: ;
                endcase
                if (in_fire) begin
                    case (state_q)
                        EMPTY: begin
                            out_flags_d = 3'b100;
                            out_sym1_d  = in_symbol;
                        end
                        ONE: begin
                            out_flags_d = 3'b110;
                            out_sym2_d  = in_symbol;
                        end
                        default: begin
                            out_flags_d = 3'b111;
                            out_sym3_d  = in_symbol;
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= EMPTY;
            held1_q     <= '0;
            held2_q     <= '0;
            out_valid_q <= 1'b0;
            out_flags_q <= 3'b000;
            out_sym1_q  <= '0;
            out_sym2_q  <= '0;
            out_sym3_q  <= '0;
            out_fl_q    <= '0;
            out_fh_q    <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            held1_q     <= held1_d;
            held2_q     <= held2_d;
            out_valid_q <= out_valid_d;
            out_flags_q <= out_flags_d;
            out_sym1_q  <= out_sym1_d;
            out_sym2_q  <= out_sym2_d;
            out_sym3_q  <= out_sym3_d;
            out_fl_q    <= out_fl_d;
            out_fh_q    <= out_fh_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_bool_flag_1 = out_flags_q[2];
    assign out_bool_flag_2 = out_flags_q[1];
    assign out_bool_flag_3 = out_flags_q[0];
    assign out_symbol_1    = out_sym1_q;
    assign out_symbol_2    = out_sym2_q;
    assign out_symbol_3    = out_sym3_q;
    assign out_fl          = out_fl_q;
    assign out_fh          = out_fh_q;
    assign out_last        = out_last_q;

endmodule

`default_nettype wire
